wifi_mac_hdr_parser: RTL and testbench

- Receive-side stage that consumes a byte stream of 802.11 MPDUs (FCS already stripped) and decodes the MAC header into registered fields.
- Decoded fields include the frame control subfields, duration, addresses and sequence control.
- Forwards the frame body on a valid/ready byte stream.
- Sits between the byte deframer and the RX frame filter/classifier, which consumes the decoded frame control flags.

---
 rtl/wifi_mac_hdr_parser.sv | 328 ++++++++++++++++++++++++++++++++
 tb/tb_wifi_mac_hdr_parser.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wifi_mac_hdr_parser.sv
`default_nettype none
// ============================================================================
//  Module      : wifi_mac_hdr_parser
//  Description : Decodes the MAC header of an 802.11 MPDU byte stream (FCS
//                already stripped) into registered fields, then forwards the
//                frame body on a valid/ready byte stream. Malformed or
//                oversize frames are flagged and drained.
//  Option      : define WIFI_HDR_QOS_CTRL_EN to parse the 2-byte QoS control
//                field of QoS data frames instead of forwarding it as body.
//  Revision    : 1.0 - initial release
// ============================================================================
module wifi_mac_hdr_parser #(
   parameter int MAX_PAYLOAD = 2304,
   parameter int PLEN_W      = 12
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        s_data,
   input  logic              s_valid,
   input  logic              s_last,
   output logic              s_ready,
   output logic [7:0]        m_data,
   output logic              m_valid,
   output logic              m_last,
   input  logic              m_ready,
   output logic              hdr_valid,
   output logic [1:0]        fc_proto,
   output logic [1:0]        fc_type,
   output logic [3:0]        fc_subtype,
   output logic [7:0]        fc_flags,
   output logic [15:0]       duration,
   output logic [47:0]       addr1,
   output logic [47:0]       addr2,
   output logic [47:0]       addr3,
   output logic [47:0]       addr4,
   output logic [15:0]       seq_ctrl,
   output logic [15:0]       qos_ctrl,
   output logic [PLEN_W-1:0] pay_len,
   output logic              frame_done,
   output logic              hdr_err,
   output logic              len_err
);

   typedef enum logic [3:0] {
      ST_FC0  = 4'd0,
      ST_FC1  = 4'd1,
      ST_DUR  = 4'd2,
      ST_A1   = 4'd3,
      ST_A2   = 4'd4,
      ST_A3   = 4'd5,
      ST_SEQ  = 4'd6,
      ST_A4   = 4'd7,
`ifdef WIFI_HDR_QOS_CTRL_EN
      ST_QOS  = 4'd8,
`endif
      ST_BODY = 4'd9,
      ST_DROP = 4'd10
   } state_t;

   // Body count just before the final allowed byte
   localparam logic [PLEN_W-1:0] c_MAX_M1 = PLEN_W'(MAX_PAYLOAD - 1);

   state_t              r_state;
   state_t              w_state_nxt;
   state_t              w_hdr_after;
   state_t              w_after_addr;
   logic [2:0]          r_idx;
   logic [2:0]          w_idx_nxt;

   logic [1:0]          r_fc_proto;
   logic [1:0]          r_fc_type;
   logic [3:0]          r_fc_subtype;
   logic [7:0]          r_fc_flags;
   logic [15:0]         r_duration;
   logic [47:0]         r_addr1;
   logic [47:0]         r_addr2;
   logic [47:0]         r_addr3;
   logic [47:0]         r_addr4;
   logic [15:0]         r_seq_ctrl;
   logic [PLEN_W-1:0]   r_pay_len;
   logic                r_hdr_valid;
   logic                r_frame_done;
   logic                r_hdr_err;
   logic                r_len_err;
   logic                r_proto_bad;

   logic                w_s_ready;
   logic                w_m_valid;
   logic                w_m_last;
   logic [7:0]          w_m_data;
   logic                w_xfer;
   logic                w_field_end;
   logic                w_ctrl;
   logic                w_at_max;
   logic                w_set_hv;
   logic                w_set_done;
   logic                w_set_herr;
   logic                w_set_lerr;

   assign w_ctrl   = (r_fc_type == 2'b01);
   assign w_at_max = (r_pay_len == c_MAX_M1);

   // Decide which header field follows the current one (ST_BODY = header complete)
   always_comb begin
      w_field_end  = 1'b1;
      w_after_addr = ST_BODY;
`ifdef WIFI_HDR_QOS_CTRL_EN
      if ((r_fc_type == 2'b10) && r_fc_subtype[3]) begin
         w_after_addr = ST_QOS;
      end
`endif
      w_hdr_after = ST_BODY;
      case (r_state)
         ST_FC0: w_hdr_after = ST_FC1;
         ST_FC1: w_hdr_after = ST_DUR;
         ST_DUR: begin
            w_field_end = (r_idx == 3'd1);
            w_hdr_after = ST_A1;
         end
         ST_A1: begin
            w_field_end = (r_idx == 3'd5);
            if (w_ctrl && ((r_fc_subtype == 4'b1100) || (r_fc_subtype == 4'b1101))) begin
               w_hdr_after = ST_BODY;
            end else begin
               w_hdr_after = ST_A2;
            end
         end
         ST_A2: begin
            w_field_end = (r_idx == 3'd5);
            if (w_ctrl) begin
               w_hdr_after = ST_BODY;
            end else begin
               w_hdr_after = ST_A3;
            end
         end
         ST_A3: begin
            w_field_end = (r_idx == 3'd5);
            w_hdr_after = ST_SEQ;
         end
         ST_SEQ: begin
            w_field_end = (r_idx == 3'd1);
            if (r_fc_flags[1:0] == 2'b11) begin
               w_hdr_after = ST_A4;
            end else begin
               w_hdr_after = w_after_addr;
            end
         end
         ST_A4: begin
            w_field_end = (r_idx == 3'd5);
            w_hdr_after = w_after_addr;
         end
`ifdef WIFI_HDR_QOS_CTRL_EN
         ST_QOS: begin
            w_field_end = (r_idx == 3'd1);
            w_hdr_after = ST_BODY;
         end
`endif
         default: w_hdr_after = ST_BODY;
      endcase
   end

   // Next-state, byte index, handshake and event-pulse decode
   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_set_hv    = 1'b0;
      w_set_done  = 1'b0;
      w_set_herr  = 1'b0;
      w_set_lerr  = 1'b0;
      w_s_ready   = 1'b1;
      w_m_valid   = 1'b0;
      w_m_last    = 1'b0;
      w_m_data    = 8'h00;
      if (r_state == ST_BODY) begin
         w_s_ready = m_ready;
         w_m_valid = s_valid;
         w_m_data  = s_data;
         w_m_last  = s_last || w_at_max;
      end
      w_xfer = s_valid && w_s_ready;
      if (w_xfer) begin
         case (r_state)
            ST_BODY: begin
               if (s_last) begin
                  w_set_done  = 1'b1;
                  w_state_nxt = ST_FC0;
               end else if (w_at_max) begin
                  w_set_lerr  = 1'b1;
                  w_state_nxt = ST_DROP;
               end
            end
            ST_DROP: begin
               if (s_last) begin
                  w_set_done  = 1'b1;
                  w_set_herr  = r_proto_bad;
                  w_state_nxt = ST_FC0;
               end
            end
            default: begin
               w_idx_nxt = w_field_end ? 3'd0 : (r_idx + 3'd1);
               if ((r_state == ST_FC0) && (s_data[1:0] != 2'b00)) begin
                  // Unsupported protocol version: drain the rest of the frame
                  if (s_last) begin
                     w_set_herr  = 1'b1;
                     w_set_done  = 1'b1;
                     w_state_nxt = ST_FC0;
                  end else begin
                     w_state_nxt = ST_DROP;
                  end
               end else if (w_field_end && (w_hdr_after == ST_BODY)) begin
                  w_set_hv = 1'b1;
                  if (s_last) begin
                     w_set_done  = 1'b1;
                     w_state_nxt = ST_FC0;
                  end else begin
                     w_state_nxt = ST_BODY;
                  end
               end else if (s_last) begin
                  // Frame ended inside the header
                  w_set_herr  = 1'b1;
                  w_set_done  = 1'b1;
                  w_idx_nxt   = 3'd0;
                  w_state_nxt = ST_FC0;
               end else if (w_field_end) begin
                  w_state_nxt = w_hdr_after;
               end
            end
         endcase
      end
   end

   // State and byte-index register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_FC0;
         r_idx   <= 3'd0;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
      end
   end

   // Header field capture (little-endian), body length count and event pulses
   always_ff @(posedge clk) begin
      if (rst) begin
         r_fc_proto   <= 2'd0;
         r_fc_type    <= 2'd0;
         r_fc_subtype <= 4'd0;
         r_fc_flags   <= 8'd0;
         r_duration   <= 16'd0;
         r_addr1      <= 48'd0;
         r_addr2      <= 48'd0;
         r_addr3      <= 48'd0;
         r_addr4      <= 48'd0;
         r_seq_ctrl   <= 16'd0;
         r_pay_len    <= '0;
         r_hdr_valid  <= 1'b0;
         r_frame_done <= 1'b0;
         r_hdr_err    <= 1'b0;
         r_len_err    <= 1'b0;
         r_proto_bad  <= 1'b0;
      end else begin
         r_hdr_valid  <= w_set_hv;
         r_frame_done <= w_set_done;
         r_hdr_err    <= w_set_herr;
         r_len_err    <= w_set_lerr;
         if (w_xfer) begin
            case (r_state)
               ST_FC0: begin
                  r_fc_proto   <= s_data[1:0];
                  r_fc_type    <= s_data[3:2];
                  r_fc_subtype <= s_data[7:4];
                  r_proto_bad  <= (s_data[1:0] != 2'b00);
                  r_pay_len    <= '0;
               end
               ST_FC1:  r_fc_flags <= s_data;
               ST_DUR:  r_duration[{r_idx[0], 3'b000} +: 8] <= s_data;
               ST_A1:   r_addr1[{r_idx, 3'b000} +: 8] <= s_data;
               ST_A2:   r_addr2[{r_idx, 3'b000} +: 8] <= s_data;
               ST_A3:   r_addr3[{r_idx, 3'b000} +: 8] <= s_data;
               ST_SEQ:  r_seq_ctrl[{r_idx[0], 3'b000} +: 8] <= s_data;
               ST_A4:   r_addr4[{r_idx, 3'b000} +: 8] <= s_data;
               ST_BODY: r_pay_len <= r_pay_len + 1'b1;
               default: ;
            endcase
         end
      end
   end

`ifdef WIFI_HDR_QOS_CTRL_EN
   logic [15:0] r_qos_ctrl;

   // QoS control capture for QoS data frames
   always_ff @(posedge clk) begin
      if (rst) begin
         r_qos_ctrl <= 16'd0;
      end else if (w_xfer && (r_state == ST_QOS)) begin
         r_qos_ctrl[{r_idx[0], 3'b000} +: 8] <= s_data;
      end
   end

   assign qos_ctrl = r_qos_ctrl;
`else
   assign qos_ctrl = 16'h0000;
`endif

   assign s_ready    = w_s_ready;
   assign m_data     = w_m_data;
   assign m_valid    = w_m_valid;
   assign m_last     = w_m_last;
   assign hdr_valid  = r_hdr_valid;
   assign fc_proto   = r_fc_proto;
   assign fc_type    = r_fc_type;
   assign fc_subtype = r_fc_subtype;
   assign fc_flags   = r_fc_flags;
   assign duration   = r_duration;
   assign addr1      = r_addr1;
   assign addr2      = r_addr2;
   assign addr3      = r_addr3;
   assign addr4      = r_addr4;
   assign seq_ctrl   = r_seq_ctrl;
   assign pay_len    = r_pay_len;
   assign frame_done = r_frame_done;
   assign hdr_err    = r_hdr_err;
   assign len_err    = r_len_err;

endmodule
`default_nettype wire

// File: tb/tb_wifi_mac_hdr_parser.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wifi_mac_hdr_parser
//  Description : Table-driven bench for wifi_mac_hdr_parser with a small
//                MAX_PAYLOAD so truncation is reachable; extra hand-written
//                reset-in-body sequence. Follows WIFI_HDR_QOS_CTRL_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wifi_mac_hdr_parser;
   localparam int MAXP = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  s_data;
   logic        s_valid, s_last, s_ready;
   logic [7:0]  m_data;
   logic        m_valid, m_last, m_ready;
   logic        hdr_valid, frame_done, hdr_err, len_err;
   logic [1:0]  fc_proto, fc_type;
   logic [3:0]  fc_subtype;
   logic [7:0]  fc_flags;
   logic [15:0] duration, seq_ctrl, qos_ctrl;
   logic [47:0] addr1, addr2, addr3, addr4;
   logic [11:0] pay_len;

   always #5 clk = ~clk;

   wifi_mac_hdr_parser #(.MAX_PAYLOAD(MAXP), .PLEN_W(12)) dut (
      .clk(clk), .rst(rst),
      .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
      .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
      .hdr_valid(hdr_valid), .fc_proto(fc_proto), .fc_type(fc_type),
      .fc_subtype(fc_subtype), .fc_flags(fc_flags), .duration(duration),
      .addr1(addr1), .addr2(addr2), .addr3(addr3), .addr4(addr4),
      .seq_ctrl(seq_ctrl), .qos_ctrl(qos_ctrl), .pay_len(pay_len),
      .frame_done(frame_done), .hdr_err(hdr_err), .len_err(len_err)
   );

   typedef struct {
      int          start, len;
      bit          tog, chk;
      int          hv, done, herr, lerr, both, plen, mcnt, off;
      logic [1:0]  ty;
      logic [3:0]  st;
      logic [7:0]  fl;
      logic [15:0] dur;
      logic [47:0] a1, a2, a4;
      logic [15:0] seq, qos;
   } vec_t;

   logic [7:0] stim[$];
   logic [7:0] mq[$];
   vec_t       tbl[$];
   vec_t       v;
   int n_cmp = 0, n_bad = 0;
   int hv_cnt, done_cnt, herr_cnt, lerr_cnt, both_cnt, mlast_cnt, mlast_idx, stalls;
   logic [11:0] pl_at_done;

   // Event monitor: samples outputs mid-cycle, away from the active edge
   always @(negedge clk) begin
      if (hdr_valid) hv_cnt++;
      if (frame_done) begin done_cnt++; pl_at_done = pay_len; end
      if (hdr_valid && frame_done) both_cnt++;
      if (hdr_err) herr_cnt++;
      if (len_err) lerr_cnt++;
      if (m_valid && m_ready) begin
         mq.push_back(m_data);
         if (m_last) begin mlast_cnt++; mlast_idx = mq.size() - 1; end
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   function automatic string nm(input int id, input string s);
      return $sformatf("v%0d.%s", id, s);
   endfunction

   function automatic void pb(input logic [7:0] b);
      stim.push_back(b);
   endfunction

   function automatic void paddr(input logic [7:0] base);
      for (int k = 0; k < 6; k++) stim.push_back(base + 8'(k));
   endfunction

   function automatic logic [47:0] aval(input logic [7:0] base);
      logic [47:0] r;
      for (int k = 0; k < 6; k++) r[8*k +: 8] = base + 8'(k);
      return r;
   endfunction

   // 24-byte three-address header
   function automatic void mkhdr(input logic [7:0] f0, input logic [7:0] f1, input logic [15:0] d,
                                 input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3,
                                 input logic [15:0] sq);
      pb(f0); pb(f1); pb(d[7:0]); pb(d[15:8]);
      paddr(b1); paddr(b2); paddr(b3);
      pb(sq[7:0]); pb(sq[15:8]);
   endfunction

   task automatic newv();
      v = '{default: 0};
      v.start = stim.size();
   endtask

   task automatic addv();
      v.len = stim.size() - v.start;
      tbl.push_back(v);
   endtask

   task automatic clr();
      hv_cnt = 0; done_cnt = 0; herr_cnt = 0; lerr_cnt = 0; both_cnt = 0;
      mlast_cnt = 0; mlast_idx = -1; stalls = 0; pl_at_done = '0;
      mq.delete();
   endtask

   // Entered and left at posedge+1
   task automatic send_byte(input logic [7:0] b, input bit last, input bit tog);
      bit acc;
      int n;
      acc = 1'b0; n = 0;
      s_data = b; s_valid = 1'b1; s_last = last;
      while (!acc && n < 50) begin
         @(negedge clk); #1;
         acc = s_ready;
         if (!acc) stalls++;
         @(posedge clk); #1;
         m_ready = tog ? ~m_ready : 1'b1;
         n++;
      end
      if (!acc) begin
         n_cmp++; n_bad++;
         $display("FAIL send_timeout: byte %0h not accepted, required within 50 cycles", b);
      end
      s_valid = 1'b0; s_last = 1'b0;
   endtask

   task automatic send_range(input int st, input int n, input bit tog, input bit with_last);
      for (int k = 0; k < n; k++) send_byte(stim[st+k], with_last && (k == n - 1), tog);
   endtask

   task automatic run_vec(input vec_t t, input int id);
      clr();
      send_range(t.start, t.len, t.tog, 1'b1);
      m_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk(nm(id, "hdr_valid_cnt"), hv_cnt, t.hv);
      chk(nm(id, "frame_done_cnt"), done_cnt, t.done);
      chk(nm(id, "hdr_err_cnt"), herr_cnt, t.herr);
      chk(nm(id, "len_err_cnt"), lerr_cnt, t.lerr);
      chk(nm(id, "hv_with_done"), both_cnt, t.both);
      chk(nm(id, "pay_len"), pl_at_done, t.plen);
      chk(nm(id, "body_cnt"), mq.size(), t.mcnt);
      chk(nm(id, "m_last_cnt"), mlast_cnt, (t.mcnt > 0) ? 1 : 0);
      if (t.mcnt > 0) chk(nm(id, "m_last_pos"), mlast_idx, t.mcnt - 1);
      for (int j = 0; j < t.mcnt; j++)
         if (j < mq.size()) chk(nm(id, $sformatf("body%0d", j)), mq[j], stim[t.start + t.off + j]);
      if (!t.tog) chk(nm(id, "s_ready_stalls"), stalls, 0);
      if (t.chk) begin
         chk(nm(id, "fc"), {fc_proto, fc_type, fc_subtype, fc_flags}, {2'b00, t.ty, t.st, t.fl});
         chk(nm(id, "duration"), duration, t.dur);
         chk(nm(id, "addr1"), addr1, t.a1);
         chk(nm(id, "addr2"), addr2, t.a2);
         chk(nm(id, "addr4"), addr4, t.a4);
         chk(nm(id, "seq_ctrl"), seq_ctrl, t.seq);
         chk(nm(id, "qos_ctrl"), qos_ctrl, t.qos);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, ".s_ready"}, s_ready, 1);
      chk({tag, ".m_out"}, {m_valid, m_last, m_data}, 0);
      chk({tag, ".pulses"}, {hdr_valid, frame_done, hdr_err, len_err}, 0);
      chk({tag, ".pay_len"}, pay_len, 0);
      chk({tag, ".addrs"}, addr1 | addr2 | addr3 | addr4, 0);
      chk({tag, ".fields"}, {fc_proto, fc_type, fc_subtype, fc_flags, duration, seq_ctrl, qos_ctrl}, 0);
   endtask

   // Watchdog
   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      int st;
      rst = 1'b1; s_data = 8'h00; s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b1;
      clr();

      // 0: plain data frame
      newv(); mkhdr(8'h08, 8'h00, 16'h002C, 8'h11, 8'h21, 8'h31, 16'h0010);
      pb(8'hAA); pb(8'hBB); pb(8'hCC); pb(8'hDD);
      v.chk = 1; v.hv = 1; v.done = 1; v.plen = 4; v.mcnt = 4; v.off = 24; v.ty = 2; v.st = 0;
      v.dur = 16'h002C; v.a1 = aval(8'h11); v.a2 = aval(8'h21); v.seq = 16'h0010; addv();
      // 1: ACK, ends on A1 byte 5
      newv(); pb(8'hD4); pb(8'h00); pb(8'h00); pb(8'h00); paddr(8'h41);
      v.chk = 1; v.hv = 1; v.done = 1; v.both = 1; v.ty = 1; v.st = 4'hD;
      v.a1 = aval(8'h41); v.a2 = aval(8'h21); v.seq = 16'h0010; addv();
      // 2: WDS frame with A4
      newv(); mkhdr(8'h08, 8'h03, 16'h0030, 8'h51, 8'h61, 8'h71, 16'h0020); paddr(8'h81);
      pb(8'h01); pb(8'h02); pb(8'h03);
      v.chk = 1; v.hv = 1; v.done = 1; v.plen = 3; v.mcnt = 3; v.off = 30; v.ty = 2; v.fl = 8'h03;
      v.dur = 16'h0030; v.a1 = aval(8'h51); v.a2 = aval(8'h61); v.a4 = aval(8'h81); v.seq = 16'h0020; addv();
      // 3: short header, last on byte 10
      newv(); pb(8'h08); pb(8'h00); pb(8'h00); pb(8'h00); paddr(8'h91); pb(8'hA1);
      v.done = 1; v.herr = 1; addv();
      // 4: valid frame after the short one
      newv(); mkhdr(8'h08, 8'h01, 16'h1234, 8'hC1, 8'hD1, 8'hE1, 16'h0035); pb(8'h5A);
      v.chk = 1; v.hv = 1; v.done = 1; v.plen = 1; v.mcnt = 1; v.off = 24; v.ty = 2; v.fl = 8'h01;
      v.dur = 16'h1234; v.a1 = aval(8'hC1); v.a2 = aval(8'hD1); v.a4 = aval(8'h81); v.seq = 16'h0035; addv();
      // 5: protocol version 1, 40 bytes drained
      newv(); pb(8'h01);
      for (int k = 0; k < 39; k++) pb(8'(k));
      v.done = 1; v.herr = 1; addv();
      // 6: oversize body, 12 bytes against MAXP=8
      newv(); mkhdr(8'h08, 8'h00, 16'h0000, 8'h11, 8'h21, 8'h31, 16'h0040);
      for (int k = 0; k < 12; k++) pb(8'hB0 + 8'(k));
      v.chk = 1; v.hv = 1; v.done = 1; v.lerr = 1; v.plen = 8; v.mcnt = 8; v.off = 24; v.ty = 2;
      v.a1 = aval(8'h11); v.a2 = aval(8'h21); v.a4 = aval(8'h81); v.seq = 16'h0040; addv();
      // 7: body with m_ready toggling every cycle
      newv(); mkhdr(8'h08, 8'h00, 16'h0000, 8'h11, 8'h21, 8'h31, 16'h0050);
      for (int k = 0; k < 6; k++) pb(8'h60 + 8'(k));
      v.tog = 1; v.chk = 1; v.hv = 1; v.done = 1; v.plen = 6; v.mcnt = 6; v.off = 24; v.ty = 2;
      v.a1 = aval(8'h11); v.a2 = aval(8'h21); v.a4 = aval(8'h81); v.seq = 16'h0050; addv();
      // 8: RTS control frame ends after A2
      newv(); pb(8'hB4); pb(8'h00); pb(8'h00); pb(8'h00); paddr(8'hF1); paddr(8'hA1);
      v.chk = 1; v.hv = 1; v.done = 1; v.both = 1; v.ty = 1; v.st = 4'hB;
      v.a1 = aval(8'hF1); v.a2 = aval(8'hA1); v.a4 = aval(8'h81); v.seq = 16'h0050; addv();
      // 9: body of exactly MAXP bytes, no truncation error
      newv(); mkhdr(8'h08, 8'h00, 16'h0000, 8'h11, 8'h21, 8'h31, 16'h0060);
      for (int k = 0; k < 8; k++) pb(8'h70 + 8'(k));
      v.chk = 1; v.hv = 1; v.done = 1; v.plen = 8; v.mcnt = 8; v.off = 24; v.ty = 2;
      v.a1 = aval(8'h11); v.a2 = aval(8'h21); v.a4 = aval(8'h81); v.seq = 16'h0060; addv();
      // 10: QoS data frame (subtype 8)
      newv(); mkhdr(8'h88, 8'h00, 16'h0000, 8'h11, 8'h21, 8'h31, 16'h0070);
      pb(8'h07); pb(8'h00); pb(8'hEE);
      v.chk = 1; v.hv = 1; v.done = 1; v.ty = 2; v.st = 4'h8;
      v.a1 = aval(8'h11); v.a2 = aval(8'h21); v.a4 = aval(8'h81); v.seq = 16'h0070;
`ifdef WIFI_HDR_QOS_CTRL_EN
      v.plen = 1; v.mcnt = 1; v.off = 26; v.qos = 16'h0007;
`else
      v.plen = 3; v.mcnt = 3; v.off = 24; v.qos = 16'h0000;
`endif
      addv();

      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk_idle("reset");
      @(posedge clk); #1;

      for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], i);

      // Reset in the middle of a body under m_ready toggling
      clr();
      st = stim.size();
      mkhdr(8'h08, 8'h00, 16'h0000, 8'h11, 8'h21, 8'h31, 16'h0080);
      pb(8'h91); pb(8'h92);
      send_range(st, 26, 1'b1, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      chk("midbody.hdr_valid_cnt", hv_cnt, 1);
      chk("midbody.body_cnt", mq.size(), 2);
      if (mq.size() == 2) chk("midbody.bytes", {mq[0], mq[1]}, 16'h9192);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; m_ready = 1'b1;
      @(negedge clk);
      chk_idle("midreset");
      @(posedge clk); #1;
      run_vec(tbl[0], 99);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
`default_nettype wire
